// File: rtl/qspi_pkg.sv
// Shared constants and helpers for the quad-SPI flash read controller:
// FSM state encoding, flash opcodes and per-phase sclk counts.
package qspi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_MODE  = 3'd3;
  localparam state_t ST_DUMMY = 3'd4;
  localparam state_t ST_DATA  = 3'd5;
  localparam state_t ST_RESP  = 3'd6;
  localparam state_t ST_CSH   = 3'd7;

  localparam logic [7:0] CMD_QIOR  = 8'hEB;
  localparam logic [7:0] MODE_BYTE = 8'h00;

  localparam int CMD_SCLKS  = 8;
  localparam int ADDR_SCLKS = 6;
  localparam int MODE_SCLKS = 2;
  localparam int DATA_SCLKS = 8;
  localparam int CSH_CYCLES = 2;

  // Index of the final sclk of a pad phase; the per-phase counter runs 0..last.
  function automatic logic [3:0] phase_last(input state_t st, input logic [3:0] dummy);
    case (st)
      ST_CMD:   return 4'(CMD_SCLKS - 1);
      ST_ADDR:  return 4'(ADDR_SCLKS - 1);
      ST_MODE:  return 4'(MODE_SCLKS - 1);
      ST_DUMMY: return dummy - 4'd1;
      ST_DATA:  return 4'(DATA_SCLKS - 1);
      default:  return 4'd0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t st);
    case (st)
      ST_CMD:   return ST_ADDR;
      ST_ADDR:  return ST_MODE;
      ST_MODE:  return ST_DUMMY;
      ST_DUMMY: return ST_DATA;
      ST_DATA:  return ST_RESP;
      default:  return ST_IDLE;
    endcase
  endfunction

  // Flash returns bytes in address order; the bus word is little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_shifter.sv
// 32-bit shift register shared by the output phases (1- or 4-bit wide,
// MSB first) and the quad data input phase.
module qspi_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift,
  input  logic        wide,
  input  logic [3:0]  din,
  output logic [31:0] q
);

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= wide ? {q[27:0], din} : {q[30:0], din[0]};
    end
  end

endmodule

// File: rtl/qspi_flash_reader.sv
// Quad I/O Fast Read (0xEB) sequencer: one 32-bit word per request, pads
// fully registered, sclk at HCLK/2.
module qspi_flash_reader
  import qspi_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  input  logic [3:0]        fdi,
  output logic [3:0]        fdo,
  output logic [3:0]        fdoe,
  output logic              fsclk,
  output logic              fcen
);

  localparam logic [3:0] DUMMY_N = 4'(DUMMY_CYCLES);

  state_t      state;
  logic        ph;        // 1: the next edge ends an sclk high half
  logic [3:0]  cnt;
  logic [31:0] sr;

  logic        hs;
  logic        active;
  logic        edge_hi;
  logic        last;
  state_t      nxt_phase;
  logic [3:0]  cnt_nxt;
  logic [23:0] addr_ext;
  logic        addr_lsb_unused;
  logic        sh_shift;
  logic        sh_wide;
  logic [3:0]  sh_din;
  logic [3:0]  pad_do;
  logic [3:0]  pad_oe;

  assign hs      = req_valid && req_ready;
  assign active  = (state >= ST_CMD) && (state <= ST_DATA);
  assign edge_hi = active && ph;
  assign last    = (cnt == phase_last(state, DUMMY_N));
  assign nxt_phase = last ? next_phase(state) : state;
  assign cnt_nxt   = last ? 4'd0 : cnt + 4'd1;

  assign addr_lsb_unused = ^req_addr[1:0];

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:2] = req_addr[ADDR_W-1:2];
  end

  // Output phases shift as each new low half starts; DATA shifts in fdi
  // on the edge that ends each high half.
  assign sh_shift = edge_hi && ((state == ST_DATA) || (nxt_phase == ST_CMD) ||
                                (nxt_phase == ST_ADDR));
  assign sh_wide  = (nxt_phase != ST_CMD);
  assign sh_din   = (state == ST_DATA) ? fdi : 4'h0;

  qspi_shifter u_shifter (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (hs),
    .load_val ({CMD_QIOR, addr_ext}),
    .shift    (sh_shift),
    .wide     (sh_wide),
    .din      (sh_din),
    .q        (sr)
  );

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned and infers a latch.
    pad_do = 4'h0;
    pad_oe = 4'h0;
    case (nxt_phase)
      ST_CMD: begin
        pad_do = {3'b000, sr[31]};
        pad_oe = 4'b0001;
      end
      ST_ADDR: begin
        pad_do = sr[31:28];
        pad_oe = 4'b1111;
      end
      ST_MODE: begin
        pad_do = cnt_nxt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        pad_oe = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      ph        <= 1'b0;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      fdo       <= 4'h0;
      fdoe      <= 4'h0;
      fsclk     <= 1'b0;
      fcen      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            // The handshake cycle acts as a virtual high half, so the first
            // real low half starts one edge later; cnt wraps F->0 there.
            state     <= ST_CMD;
            ph        <= 1'b1;
            cnt       <= 4'hF;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_CSH;
            cnt       <= 4'd0;
          end
        end
        ST_CSH: begin
          if (cnt == 4'(CSH_CYCLES - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          if (!ph) begin
            fsclk <= 1'b1;
            ph    <= 1'b1;
          end else begin
            fsclk <= 1'b0;
            ph    <= 1'b0;
            cnt   <= cnt_nxt;
            state <= nxt_phase;
            if (nxt_phase == ST_RESP) begin
              fcen      <= 1'b1;
              fdo       <= 4'h0;
              fdoe      <= 4'h0;
              rsp_valid <= 1'b1;
              rsp_data  <= byte_swap({sr[27:0], fdi});
            end else begin
              fcen <= 1'b0;
              fdo  <= pad_do;
              fdoe <= pad_oe;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: behavioural quad flash, scoreboard of
// expected words, table of reads plus reset and back-to-back sequences.
module tb_qspi_flash_reader;

  localparam int ADDR_W = 24;
  localparam int DUMMY  = 4;
  localparam int NSCLK  = 24 + DUMMY;
  localparam int LAT    = 2 * (24 + DUMMY) + 1;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [3:0]        fdi = 4'h0;
  logic [3:0]        fdo;
  logic [3:0]        fdoe;
  logic              fsclk;
  logic              fcen;

  qspi_flash_reader #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .fdi       (fdi),
    .fdo       (fdo),
    .fdoe      (fdoe),
    .fsclk     (fsclk),
    .fcen      (fcen)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a[23:2] == 22'h40) begin
      case (a[1:0])
        2'd0:    return 8'h11;
        2'd1:    return 8'h22;
        2'd2:    return 8'h33;
        default: return 8'h44;
      endcase
    end
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] al;
    al = {a[23:2], 2'b00};
    return {mem_byte(al + 24'd3), mem_byte(al + 24'd2), mem_byte(al + 24'd1), mem_byte(al)};
  endfunction

  function automatic logic [3:0] exp_oe(input int idx);
    if (idx < 8)  return 4'b0001;
    if (idx < 16) return 4'b1111;
    return 4'b0000;
  endfunction

  // Scoreboard queues, filled at handshake and drained on response / deselect.
  logic [31:0] data_q[$];
  logic [23:0] addr_q[$];
  int hs_count = 0;
  int hs_last = 0;
  int hs_prev = 0;

  // Flash model and pad monitor, sampling mid-cycle on the falling HCLK edge.
  logic        prev_fcen = 1'b1;
  logic        prev_sclk = 1'b0;
  int          sclk_n = 0;
  int          fcen_hi = 0;
  bit          had_txn = 1'b0;
  logic [7:0]  cmd_sh;
  logic [23:0] adr_sh;
  logic [7:0]  mode_sh;
  int          m_idx;
  int          m_j;
  logic [7:0]  m_b;

  always @(negedge HCLK) begin
    if (HRESET) begin
      data_q.delete();
      addr_q.delete();
      prev_fcen = 1'b1;
      prev_sclk = 1'b0;
      sclk_n = 0;
      fcen_hi = 0;
      had_txn = 1'b0;
      fdi = 4'($urandom);
    end else begin
      if (req_valid && req_ready) begin
        data_q.push_back(exp_word(req_addr));
        addr_q.push_back({req_addr[23:2], 2'b00});
        hs_prev = hs_last;
        hs_last = cyc + 1;
        hs_count++;
      end
      if (rsp_valid && rsp_ready) begin
        if (data_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_data_sb", rsp_data, data_q.pop_front());
      end
      if (prev_fcen && !fcen) begin
        if (had_txn) check("fcen_gap_ge2", 32'(fcen_hi >= 2), 32'd1);
        sclk_n = 0;
        cmd_sh = '0;
        adr_sh = '0;
        mode_sh = '0;
      end
      fdi = 4'($urandom);
      if (!fcen && fsclk && !prev_sclk) begin
        m_idx = sclk_n;
        sclk_n++;
        check("fdoe_phase", 32'(fdoe), 32'(exp_oe(m_idx)));
        if (m_idx < 8) begin
          cmd_sh = {cmd_sh[6:0], fdo[0]};
        end else if (m_idx < 14) begin
          adr_sh = {adr_sh[19:0], fdo};
        end else if (m_idx < 16) begin
          mode_sh = {mode_sh[3:0], fdo};
        end else if (m_idx >= 16 + DUMMY && m_idx < NSCLK) begin
          m_j = m_idx - 16 - DUMMY;
          m_b = mem_byte(adr_sh + 24'(m_j / 2));
          fdi = m_j[0] ? m_b[3:0] : m_b[7:4];
        end
      end
      if (!prev_fcen && fcen) begin
        had_txn = 1'b1;
        check("sclk_count", 32'(sclk_n), 32'(NSCLK));
        check("cmd_byte", 32'(cmd_sh), 32'h0000_00EB);
        check("mode_byte", 32'(mode_sh), 32'h0);
        if (addr_q.size() == 0) check("addr_unexpected", 32'd1, 32'd0);
        else check("addr_bus", 32'(adr_sh), 32'(addr_q.pop_front()));
      end
      fcen_hi = fcen ? fcen_hi + 1 : 0;
      prev_fcen = fcen;
      prev_sclk = fsclk;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [23:0] a, input int dly, input logic [31:0] exp);
    int n;
    int t0;
    int ta;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    step();
    t0 = cyc;
    req_valid = 1'b0;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("fcen_setup", 32'(fcen), 32'd1);
    n = 0;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    check("rsp_latency", 32'(cyc - t0), 32'(LAT));
    check("rsp_data", rsp_data, exp);
    repeat (dly) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, exp);
      check("hold_fcen", 32'(fcen), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    ta = cyc;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_gap", 32'(cyc - ta), 32'd2);
  endtask

  typedef struct {
    logic [23:0] addr;
    int          dly;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_fdo", 32'(fdo), 32'h0);
    check("rst_fdoe", 32'(fdoe), 32'h0);
    check("rst_fsclk", 32'(fsclk), 32'd0);
    check("rst_fcen", 32'(fcen), 32'd1);
    HRESET = 1'b0;
    step();
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    vecs[0] = '{24'h000100, 0,  32'h44332211};
    vecs[1] = '{24'h000103, 0,  32'h44332211};
    vecs[2] = '{24'hABCDE4, 10, exp_word(24'hABCDE4)};
    vecs[3] = '{24'hFFFFFC, 1,  exp_word(24'hFFFFFC)};
    vecs[4] = '{24'h000000, 0,  exp_word(24'h000000)};
    vecs[5] = '{24'h5A5A5B, 2,  exp_word(24'h5A5A5B)};
    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].addr, vecs[i].dly, vecs[i].exp);
    end

    // Back-to-back: request held high, consumer always ready.
    wait_ready();
    rsp_ready = 1'b1;
    req_addr  = 24'h000040;
    req_valid = 1'b1;
    base = hs_count;
    n = 0;
    while (hs_count < base + 2 && n < 200) begin
      step();
      n++;
    end
    req_valid = 1'b0;
    check("b2b_handshakes", 32'(hs_count - base), 32'd2);
    check("b2b_spacing_ge60", 32'((hs_last - hs_prev) >= LAT + 3), 32'd1);
    n = 0;
    while (!(req_ready && data_q.size() == 0) && n < 200) begin
      step();
      n++;
    end
    check("b2b_drained", 32'(data_q.size()), 32'd0);
    rsp_ready = 1'b0;

    // Reset in the middle of the address phase.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 24'h000200;
    step();
    req_valid = 1'b0;
    repeat (20) step();
    check("pre_rst_fdoe", 32'(fdoe), 32'hF);
    check("pre_rst_fcen", 32'(fcen), 32'd0);
    HRESET = 1'b1;
    #1;
    check("abort_fcen", 32'(fcen), 32'd1);
    check("abort_fsclk", 32'(fsclk), 32'd0);
    check("abort_fdoe", 32'(fdoe), 32'h0);
    check("abort_fdo", 32'(fdo), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    step();
    HRESET = 1'b0;
    step();
    check("req_ready_after_abort", 32'(req_ready), 32'd1);
    do_read(24'h000100, 3, 32'h44332211);
    do_read(24'h123456, 0, exp_word(24'h123456));

    repeat (5) step();
    check("final_data_q_empty", 32'(data_q.size()), 32'd0);
    check("final_addr_q_empty", 32'(addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
